// File: rtl/dpm_pkg.sv
// Shared types and stream-size constants for the DPM feed path.
package dpm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WAIT_DONE,
    START,
    EMIT
  } state_t;

  localparam int DEF_GROUP_ROWS  = 4;
  localparam int DEF_KERNEL_SIZE = 3;

  localparam int FEAT_WORDS   = DEF_GROUP_ROWS * DEF_GROUP_ROWS;
  localparam int OFF_WORDS    = 2 * DEF_KERNEL_SIZE * DEF_KERNEL_SIZE;
  localparam int STREAM_WORDS = FEAT_WORDS + OFF_WORDS;

  function automatic int feat_words(input int rows);
    return rows * rows;
  endfunction

  function automatic int off_words(input int ksize);
    return 2 * ksize * ksize;
  endfunction

endpackage

// File: rtl/dpm_feed_tx_offset_sat.sv
// offset_sat: combinational signed clip of a fixed-point offset to
// [-(OFF_INT_MAX<<FRAC_BITS), (OFF_INT_MAX<<FRAC_BITS) + 2^FRAC_BITS - 1].
module offset_sat #(
  parameter int DATA_W      = 16,
  parameter int FRAC_BITS   = 8,
  parameter int OFF_INT_MAX = 7
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_clipped
);

  localparam int HI = (OFF_INT_MAX << FRAC_BITS) + (1 << FRAC_BITS) - 1;
  localparam int LO = -(OFF_INT_MAX << FRAC_BITS);
  localparam logic signed [DATA_W-1:0] HI_W = DATA_W'(HI);
  localparam logic signed [DATA_W-1:0] LO_W = DATA_W'(LO);

  logic signed [DATA_W-1:0] w_in;
  assign w_in = $signed(i_data);

  always_comb begin
    o_data    = i_data;
    o_clipped = 1'b0;
    if (w_in > HI_W) begin
      o_data    = HI_W;
      o_clipped = 1'b1;
    end else if (w_in < LO_W) begin
      o_data    = LO_W;
      o_clipped = 1'b1;
    end
  end

endmodule

// File: rtl/dpm_feed_tx.sv
// dpm_feed_tx: gathers one feature/offset group, pushes it to the DPM input FIFO
// and pulses dpm_start. Optional sat_cnt output under DPM_FEED_TX_SAT_CNT_EN.
module dpm_feed_tx
  import dpm_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int GROUP_ROWS  = DEF_GROUP_ROWS,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int FRAC_BITS   = 8,
  parameter int OFF_INT_MAX = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] feat_in_data,
  input  logic              feat_in_valid,
  output logic              feat_in_ready,
  input  logic [DATA_W-1:0] off_in_data,
  input  logic              off_in_valid,
  output logic              off_in_ready,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  input  logic              grp_done,
  output logic              dpm_start,
  output logic              busy,
`ifdef DPM_FEED_TX_SAT_CNT_EN
  output logic [15:0]       sat_cnt,
`endif
  output logic [15:0]       groups_sent
);

  localparam int NFEAT = feat_words(GROUP_ROWS);
  localparam int NOFF  = off_words(KERNEL_SIZE);
  localparam int NSTR  = NFEAT + NOFF;
  localparam int FC_W  = $clog2(NFEAT + 1);
  localparam int OC_W  = $clog2(NOFF + 1);
  localparam int IDX_W = $clog2(NSTR);

  state_t            r_state, w_next;
  logic [FC_W-1:0]   r_feat_cnt;
  logic [OC_W-1:0]   r_off_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_credit;
  logic [15:0]       r_groups;
  logic [DATA_W-1:0] r_words [NSTR];

  logic              w_feat_rdy, w_off_rdy, w_wr_en, w_start, w_last;
  logic              w_feat_acc, w_off_acc, w_off_clip;
  logic [DATA_W-1:0] w_off_sat, w_wr_data;

  offset_sat #(
    .DATA_W      (DATA_W),
    .FRAC_BITS   (FRAC_BITS),
    .OFF_INT_MAX (OFF_INT_MAX)
  ) u_sat (
    .i_data    (off_in_data),
    .o_data    (w_off_sat),
    .o_clipped (w_off_clip)
  );

  always_comb begin
    w_next     = r_state;
    w_feat_rdy = 1'b0;
    w_off_rdy  = 1'b0;
    w_wr_en    = 1'b0;
    w_start    = 1'b0;
    w_wr_data  = '0;
    case (r_state)
      IDLE: w_next = COLLECT;
      COLLECT: begin
        w_feat_rdy = (r_feat_cnt != FC_W'(NFEAT));
        w_off_rdy  = (r_off_cnt  != OC_W'(NOFF));
        if (!w_feat_rdy && !w_off_rdy) w_next = r_credit ? START : WAIT_DONE;
      end
      // grp_done is seen directly so START follows it by a single cycle
      WAIT_DONE: if (r_credit || grp_done) w_next = START;
      START: begin
        w_start = 1'b1;
        w_next  = EMIT;
      end
      EMIT: begin
        w_wr_en   = !fifo_full;
        w_wr_data = r_words[r_idx];
        if (w_wr_en && (r_idx == IDX_W'(NSTR - 1))) w_next = COLLECT;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_feat_acc = w_feat_rdy && feat_in_valid;
  assign w_off_acc  = w_off_rdy && off_in_valid;
  assign w_last     = w_wr_en && (r_idx == IDX_W'(NSTR - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_feat_cnt <= '0;
      r_off_cnt  <= '0;
      r_idx      <= '0;
      r_credit   <= 1'b1;
      r_groups   <= '0;
    end else begin
      r_state <= w_next;
      if (w_feat_acc) r_feat_cnt <= r_feat_cnt + 1'b1;
      if (w_off_acc)  r_off_cnt  <= r_off_cnt + 1'b1;
      if (w_start)    r_idx      <= '0;
      else if (w_wr_en) r_idx    <= r_idx + 1'b1;
      if (w_last) begin
        r_groups   <= r_groups + 16'd1;
        r_feat_cnt <= '0;
        r_off_cnt  <= '0;
        r_idx      <= '0;
      end
      if (grp_done)     r_credit <= 1'b1;
      else if (w_start) r_credit <= 1'b0;
    end
  end

  // Word storage in emit order: features first, then x offsets, then y offsets
  always_ff @(posedge clk) begin
    if (w_feat_acc) r_words[IDX_W'(r_feat_cnt)] <= feat_in_data;
    if (w_off_acc)  r_words[IDX_W'(NFEAT) + IDX_W'(r_off_cnt)] <= w_off_sat;
  end

`ifdef DPM_FEED_TX_SAT_CNT_EN
  logic [15:0] r_sat_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_sat_cnt <= '0;
    else if (w_off_acc && w_off_clip && (r_sat_cnt != 16'hFFFF)) r_sat_cnt <= r_sat_cnt + 16'd1;
  end
  assign sat_cnt = r_sat_cnt;
`else
  logic w_unused_clip;
  assign w_unused_clip = w_off_clip;
`endif

  assign feat_in_ready = w_feat_rdy;
  assign off_in_ready  = w_off_rdy;
  assign fifo_wr_en    = w_wr_en;
  assign fifo_wr_data  = w_wr_data;
  assign dpm_start     = w_start;
  assign busy          = (r_state != IDLE);
  assign groups_sent   = r_groups;

endmodule

// File: tb/tb_dpm_feed_tx.sv
// Directed self-checking bench for dpm_feed_tx (checks sat_cnt when DPM_FEED_TX_SAT_CNT_EN is set).
module tb_dpm_feed_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] feat_in_data, off_in_data, fifo_wr_data, groups_sent;
  logic        feat_in_valid, feat_in_ready, off_in_valid, off_in_ready;
  logic        fifo_full, fifo_wr_en, grp_done, dpm_start, busy;
`ifdef DPM_FEED_TX_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [15:0] g_feat [16];
  logic [15:0] g_off  [18];
  logic [15:0] exp_w  [dpm_pkg::STREAM_WORDS];
  logic [15:0] cap_w  [dpm_pkg::STREAM_WORDS];

  always #5 clk = ~clk;

  dpm_feed_tx #(.DATA_W(16), .GROUP_ROWS(4), .KERNEL_SIZE(3), .FRAC_BITS(8), .OFF_INT_MAX(7)) dut (
    .clk(clk), .rst(rst),
    .feat_in_data(feat_in_data), .feat_in_valid(feat_in_valid), .feat_in_ready(feat_in_ready),
    .off_in_data(off_in_data), .off_in_valid(off_in_valid), .off_in_ready(off_in_ready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .grp_done(grp_done), .dpm_start(dpm_start), .busy(busy),
`ifdef DPM_FEED_TX_SAT_CNT_EN
    .sat_cnt(sat_cnt),
`endif
    .groups_sent(groups_sent)
  );

  function automatic logic [15:0] sat_model(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    if (s > 2047) return 16'h07FF;
    if (s < -1792) return 16'hF900;
    return v;
  endfunction

  task automatic build_exp();
    for (int i = 0; i < 16; i++) exp_w[i] = g_feat[i];
    for (int j = 0; j < 18; j++) exp_w[16+j] = sat_model(g_off[j]);
  endtask

  task automatic pulse_grp_done();
    @(posedge clk); #1 grp_done = 1'b1;
    @(posedge clk); #1 grp_done = 1'b0;
  endtask

  task automatic feed(input bit skew);
    int fi = 0, oi = 0, cyc = 0;
    while ((fi < 16 || oi < 18) && cyc < 400) begin
      @(posedge clk); #1;
      feat_in_valid = (fi < 16) && (!skew || (oi == 18 && (cyc % 2) == 0));
      feat_in_data  = (fi < 16) ? g_feat[fi] : 16'h0000;
      off_in_valid  = (oi < 18);
      off_in_data   = (oi < 18) ? g_off[oi] : 16'h0000;
      @(negedge clk);
      if (skew && oi == 18) begin
        checks++;
        if (off_in_ready !== 1'b0) begin
          failures++; $display("FAIL skew_off_ready_drop got=%b exp=0", off_in_ready);
        end
      end
      if (feat_in_valid && feat_in_ready) fi++;
      if (off_in_valid && off_in_ready) oi++;
      cyc++;
    end
    @(posedge clk); #1;
    feat_in_valid = 1'b0;
    off_in_valid  = 1'b0;
    checks++;
    if (fi != 16 || oi != 18) begin
      failures++; $display("FAIL feed_timeout got=%0d/%0d exp=16/18", fi, oi);
    end
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (dpm_start === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL wait_start got=none exp=dpm_start");
    end
  endtask

  // Starts on the cycle after dpm_start; returns number of EMIT cycles used.
  task automatic run_emit(input int stall3, input int stall33, output int cycles);
    int n = 0, s3 = 0, s33 = 0;
    cycles = 0;
    while (n < 34 && cycles < 200) begin
      @(posedge clk); #1;
      fifo_full = 1'b0;
      if (n == 3 && s3 < stall3) begin fifo_full = 1'b1; s3++; end
      if (n == 33 && s33 < stall33) begin fifo_full = 1'b1; s33++; end
      @(negedge clk);
      cycles++;
      checks++;
      if (dpm_start !== 1'b0) begin
        failures++; $display("FAIL emit_start_once got=%b exp=0 at n=%0d", dpm_start, n);
      end
      if (fifo_full) begin
        checks++;
        if (fifo_wr_en !== 1'b0) begin
          failures++; $display("FAIL write_while_full got=%b exp=0 at n=%0d", fifo_wr_en, n);
        end
        if (n == 3) begin
          checks++;
          if (fifo_wr_data !== exp_w[3]) begin
            failures++; $display("FAIL hold_data got=%h exp=%h", fifo_wr_data, exp_w[3]);
          end
        end
      end else begin
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_data !== exp_w[n]) begin
          failures++; $display("FAIL emit_word[%0d] got=%b/%h exp=1/%h", n, fifo_wr_en, fifo_wr_data, exp_w[n]);
        end
      end
      if (fifo_wr_en === 1'b1) begin cap_w[n] = fifo_wr_data; n++; end
    end
    @(posedge clk); #1 fifo_full = 1'b0;
    checks++;
    if (n != 34) begin
      failures++; $display("FAIL emit_count got=%0d exp=34", n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({feat_in_ready, off_in_ready, fifo_wr_en, dpm_start, busy} !== 5'b0 ||
        fifo_wr_data !== 16'h0 || groups_sent !== 16'h0) begin
      failures++; $display("FAIL reset_outputs got=%b/%h/%h exp=00000/0000/0000",
        {feat_in_ready, off_in_ready, fifo_wr_en, dpm_start, busy}, fifo_wr_data, groups_sent);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset got=%b exp=0", busy); end
    @(negedge clk);
    checks++;
    if ({busy, feat_in_ready, off_in_ready} !== 3'b111) begin
      failures++; $display("FAIL collect_entry got=%b exp=111", {busy, feat_in_ready, off_in_ready});
    end
  endtask

  task automatic test_basic();
    bit seen;
    int cyc;
    for (int i = 0; i < 16; i++) g_feat[i] = 16'(i + 1);
    for (int k = 0; k < 9; k++) begin
      g_off[k]   = 16'(16'h0100 * k);
      g_off[9+k] = 16'(-(16'h0080 * k));
    end
    build_exp();
    feed(1'b0);
    wait_start(seen);
    run_emit(0, 0, cyc);
    checks++;
    if (cyc != 34) begin failures++; $display("FAIL basic_cycles got=%0d exp=34", cyc); end
    checks++;
    if (cap_w[24] !== 16'h07FF) begin failures++; $display("FAIL basic_x8_clip got=%h exp=07FF", cap_w[24]); end
    @(negedge clk);
    checks++;
    if (groups_sent !== 16'd1) begin failures++; $display("FAIL basic_groups got=%0d exp=1", groups_sent); end
  endtask

  task automatic test_credit();
    for (int i = 0; i < 16; i++) g_feat[i] = 16'hA000 + 16'(i);
    g_off[0] = 16'h7F00;
    g_off[9] = 16'h8000;
    for (int k = 1; k < 9; k++) begin
      g_off[k]   = 16'(16'h0010 * k);
      g_off[9+k] = 16'(-(16'h0010 * k));
    end
    build_exp();
    feed(1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, dpm_start, feat_in_ready, off_in_ready, fifo_wr_en} !== 5'b10000) begin
        failures++; $display("FAIL credit_hold got=%b exp=10000",
          {busy, dpm_start, feat_in_ready, off_in_ready, fifo_wr_en});
      end
    end
    @(posedge clk); #1 grp_done = 1'b1;
    @(negedge clk);
    checks++;
    if (dpm_start !== 1'b0) begin failures++; $display("FAIL credit_start_early got=%b exp=0", dpm_start); end
    @(posedge clk); #1 grp_done = 1'b0;
    @(negedge clk);
    checks++;
    if (dpm_start !== 1'b1) begin failures++; $display("FAIL credit_start got=%b exp=1", dpm_start); end
  endtask

  task automatic test_backpressure();
    int cyc;
    run_emit(5, 1, cyc);
    checks++;
    if (cyc != 40) begin failures++; $display("FAIL bp_cycles got=%0d exp=40", cyc); end
    checks++;
    if (cap_w[16] !== 16'h07FF || cap_w[25] !== 16'hF900) begin
      failures++; $display("FAIL saturation got=%h/%h exp=07FF/F900", cap_w[16], cap_w[25]);
    end
    @(negedge clk);
    checks++;
    if (groups_sent !== 16'd2) begin failures++; $display("FAIL bp_groups got=%0d exp=2", groups_sent); end
`ifdef DPM_FEED_TX_SAT_CNT_EN
    checks++;
    if (sat_cnt !== 16'd3) begin failures++; $display("FAIL sat_cnt got=%0d exp=3", sat_cnt); end
`endif
  endtask

  task automatic test_skew();
    bit seen;
    int cyc;
    for (int i = 0; i < 16; i++) g_feat[i] = 16'h5500 + 16'(3 * i);
    for (int k = 0; k < 9; k++) begin
      g_off[k]   = 16'(16'h0021 * k);
      g_off[9+k] = 16'(16'hFF00 - 16'h0011 * k);
    end
    build_exp();
    pulse_grp_done();
    feed(1'b1);
    wait_start(seen);
    run_emit(0, 0, cyc);
    @(negedge clk);
    checks++;
    if (groups_sent !== 16'd3) begin failures++; $display("FAIL skew_groups got=%0d exp=3", groups_sent); end
  endtask

  task automatic test_mid_reset();
    bit seen;
    int n = 0;
    for (int i = 0; i < 16; i++) g_feat[i] = 16'h1200 + 16'(i);
    for (int k = 0; k < 18; k++) g_off[k] = 16'(16'h0040 + k);
    build_exp();
    pulse_grp_done();
    feed(1'b0);
    wait_start(seen);
    while (n < 20) begin
      @(negedge clk);
      if (fifo_wr_en === 1'b1) n++;
      if (dpm_start === 1'b0 && fifo_wr_en === 1'b0) n = 20;
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({feat_in_ready, off_in_ready, fifo_wr_en, dpm_start, busy} !== 5'b0 ||
        fifo_wr_data !== 16'h0 || groups_sent !== 16'h0) begin
      failures++; $display("FAIL midreset_outputs got=%b/%h/%h exp=00000/0000/0000",
        {feat_in_ready, off_in_ready, fifo_wr_en, dpm_start, busy}, fifo_wr_data, groups_sent);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b0 || dpm_start !== 1'b0) begin
        failures++; $display("FAIL midreset_quiet got=%b/%b exp=0/0", fifo_wr_en, dpm_start);
      end
    end
    feed(1'b0);
    wait_start(seen);
    begin
      int cyc;
      run_emit(0, 0, cyc);
    end
    @(negedge clk);
    checks++;
    if (groups_sent !== 16'd1) begin failures++; $display("FAIL postreset_groups got=%0d exp=1", groups_sent); end
  endtask

  initial begin
    rst = 1'b1; feat_in_data = '0; feat_in_valid = 1'b0; off_in_data = '0; off_in_valid = 1'b0;
    fifo_full = 1'b0; grp_done = 1'b0;
    test_reset();
    test_basic();
    test_credit();
    test_backpressure();
    test_skew();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
